// File: rtl/segment_port_arbiter_pkg.sv
// Shared types and constants for the segment register file port arbiter.
package segment_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ES = 2'd0,
    CS = 2'd1,
    SS = 2'd2,
    DS = 2'd3
  } seg_reg_e;

  localparam int unsigned SEG_W  = 2;
  localparam int unsigned DATA_W = 16;

  // Read requester indices.
  localparam int unsigned RD_MC  = 0;
  localparam int unsigned RD_LS  = 1;
  localparam int unsigned RD_DBG = 2;

  function automatic logic is_ss(input logic [SEG_W-1:0] sel);
    return sel == SS;
  endfunction

endpackage

// File: rtl/segment_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, pointer names the highest-priority index.
module rr_arbiter #(
  parameter int unsigned WIDTH = 3,
  localparam int unsigned PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] req,
  input  logic             adv,
  output logic [WIDTH-1:0] grant
);

  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0] cand, win_idx;
  logic             found;

  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int unsigned off);
    int unsigned s;
    s = {{(32-PTR_W){1'b0}}, base} + off;
    return PTR_W'(s % WIDTH);
  endfunction

  always_comb begin
    grant   = '0;
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      cand = wrap_add(rr_ptr_q, k);
      if (!found && req[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
    if (found) grant[win_idx] = 1'b1;

    rr_ptr_d = rr_ptr_q;
    if (adv && found) rr_ptr_d = wrap_add(win_idx, 1);
  end

  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/segment_port_arbiter.sv
// Shares the segment register file read/write ports: round-robin reads,
// fixed-priority writes (microcode over debug), tagged read data next cycle.
module segment_port_arbiter
  import segment_port_arbiter_pkg::*;
#(
  parameter int unsigned NUM_RD = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_RD-1:0]   rd_req,
  input  logic [2*NUM_RD-1:0] rd_sel,
  output logic [NUM_RD-1:0]   rd_ack,
  output logic [NUM_RD-1:0]   rd_valid,
  output logic [15:0]         rd_data,
  input  logic                mc_wr_en,
  input  logic [1:0]          mc_wr_sel,
  input  logic [15:0]         mc_wr_val,
  input  logic                dbg_wr_req,
  input  logic [1:0]          dbg_wr_sel,
  input  logic [15:0]         dbg_wr_val,
  output logic                dbg_wr_ack,
  output logic [1:0]          srf_rd_sel,
  input  logic [15:0]         srf_rd_val,
  output logic                srf_wr_en,
  output logic [1:0]          srf_wr_sel,
  output logic [15:0]         srf_wr_val,
  output logic                ss_loaded
);

  logic [NUM_RD-1:0] rd_req_eff;
  logic [NUM_RD-1:0] grant;
  logic [NUM_RD-1:0] grant_q, grant_d;
  logic              ss_loaded_q, ss_loaded_d;

  // Requests are masked during reset so no grant fires and the pointer holds at 0.
  always_comb begin
    rd_req_eff = reset ? '0 : rd_req;
  end

  rr_arbiter #(
    .WIDTH (NUM_RD)
  ) u_rr_arbiter (
    .clk   (clk),
    .reset (reset),
    .req   (rd_req_eff),
    .adv   (1'b1),
    .grant (grant)
  );

  always_comb begin
    srf_rd_sel = ES;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      if (grant[i]) srf_rd_sel = rd_sel[2*i +: 2];
    end
  end

  always_comb begin
    grant_d  = grant;
    rd_ack   = grant;
    // A read in flight when reset rises is dropped, not delivered.
    rd_valid = reset ? '0 : grant_q;
    rd_data  = srf_rd_val;
  end

  always_comb begin
    srf_wr_en   = ~reset & (mc_wr_en | dbg_wr_req);
    dbg_wr_ack  = ~reset & dbg_wr_req & ~mc_wr_en;
    srf_wr_sel  = mc_wr_en ? mc_wr_sel : dbg_wr_sel;
    srf_wr_val  = mc_wr_en ? mc_wr_val : dbg_wr_val;
    ss_loaded_d = srf_wr_en & is_ss(srf_wr_sel);
    ss_loaded   = ~reset & ss_loaded_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q     <= '0;
      ss_loaded_q <= 1'b0;
    end else begin
      grant_q     <= grant_d;
      ss_loaded_q <= ss_loaded_d;
    end
  end

endmodule

// File: tb/tb_segment_port_arbiter.sv
// Self-checking bench for segment_port_arbiter with a segment file model.
module tb_segment_port_arbiter;
  import segment_port_arbiter_pkg::*;

  localparam int N = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    rd_req;
  logic [2*N-1:0]  rd_sel;
  logic [N-1:0]    rd_ack, rd_valid;
  logic [15:0]     rd_data;
  logic            mc_wr_en;
  logic [1:0]      mc_wr_sel;
  logic [15:0]     mc_wr_val;
  logic            dbg_wr_req;
  logic [1:0]      dbg_wr_sel;
  logic [15:0]     dbg_wr_val;
  logic            dbg_wr_ack;
  logic [1:0]      srf_rd_sel;
  logic [15:0]     srf_rd_val;
  logic            srf_wr_en;
  logic [1:0]      srf_wr_sel;
  logic [15:0]     srf_wr_val;
  logic            ss_loaded;

  always #5 clk = ~clk;

  segment_port_arbiter #(.NUM_RD(N)) dut (
    .clk(clk), .reset(reset),
    .rd_req(rd_req), .rd_sel(rd_sel), .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
    .mc_wr_en(mc_wr_en), .mc_wr_sel(mc_wr_sel), .mc_wr_val(mc_wr_val),
    .dbg_wr_req(dbg_wr_req), .dbg_wr_sel(dbg_wr_sel), .dbg_wr_val(dbg_wr_val), .dbg_wr_ack(dbg_wr_ack),
    .srf_rd_sel(srf_rd_sel), .srf_rd_val(srf_rd_val),
    .srf_wr_en(srf_wr_en), .srf_wr_sel(srf_wr_sel), .srf_wr_val(srf_wr_val),
    .ss_loaded(ss_loaded)
  );

  // Segment register file: registered read with same-cycle write bypass.
  logic [15:0] file_mem [4];
  always @(posedge clk) begin
    if (srf_wr_en) file_mem[srf_wr_sel] <= srf_wr_val;
    srf_rd_val <= (srf_wr_en && srf_wr_sel == srf_rd_sel) ? srf_wr_val : file_mem[srf_rd_sel];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Behavioural model: pointer as integer, segment contents as array.
  int          m_ptr = 0;
  int          m_pend = -1;
  logic [15:0] m_pend_data;
  bit          m_ss = 1'b0;
  logic [15:0] m_seg [4];
  int          g;
  logic [N-1:0] e_ack, e_valid;
  logic [1:0]  e_sel, w_sel;
  logic [15:0] w_val;
  bit          w_en;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_rd_ack", rd_ack, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_dbg_wr_ack", dbg_wr_ack, 0);
      chk("rst_srf_wr_en", srf_wr_en, 0);
      chk("rst_ss_loaded", ss_loaded, 0);
      m_ptr  = 0;
      m_pend = -1;
      m_ss   = 1'b0;
    end else begin
      e_valid = '0;
      if (m_pend >= 0) e_valid[m_pend] = 1'b1;
      chk("rd_valid", rd_valid, e_valid);
      if (m_pend >= 0) chk("rd_data", rd_data, m_pend_data);
      chk("ss_loaded", ss_loaded, m_ss);

      g = -1;
      for (int k = 0; k < N; k++) begin
        if (g < 0 && rd_req[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      e_ack = '0;
      e_sel = 2'd0;
      if (g >= 0) begin
        e_ack[g] = 1'b1;
        e_sel    = rd_sel[2*g +: 2];
      end
      chk("rd_ack", rd_ack, e_ack);
      chk("srf_rd_sel", srf_rd_sel, e_sel);

      w_en  = mc_wr_en || dbg_wr_req;
      w_sel = mc_wr_en ? mc_wr_sel : dbg_wr_sel;
      w_val = mc_wr_en ? mc_wr_val : dbg_wr_val;
      chk("srf_wr_en", srf_wr_en, w_en);
      if (w_en) begin
        chk("srf_wr_sel", srf_wr_sel, w_sel);
        chk("srf_wr_val", srf_wr_val, w_val);
      end
      chk("dbg_wr_ack", dbg_wr_ack, !mc_wr_en && dbg_wr_req);

      if (w_en) m_seg[w_sel] = w_val;
      if (g >= 0) begin
        m_pend      = g;
        m_pend_data = m_seg[e_sel];
        m_ptr       = (g + 1) % N;
      end else begin
        m_pend = -1;
      end
      m_ss = w_en && (w_sel == SS);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [N-1:0] order [6];
  logic [3:0]   dack;
  logic [1:0]   rsel [3];
  logic [15:0]  rexp [3];
  int           ssc, cnt2;

  initial begin
    for (int i = 0; i < 4; i++) begin
      file_mem[i] = 16'h0;
      m_seg[i]    = 16'h0;
    end
    srf_rd_val = 16'h0;
    reset = 1'b1; rd_req = '0; rd_sel = '0;
    mc_wr_en = 1'b0; mc_wr_sel = 2'd0; mc_wr_val = 16'h0;
    dbg_wr_req = 1'b0; dbg_wr_sel = 2'd0; dbg_wr_val = 16'h0;
    cyc(); cyc();
    @(negedge clk);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_ss_loaded", ss_loaded, 0);
    cyc();
    reset = 1'b0;

    // Preload DS, then a single load/store read.
    mc_wr_en = 1'b1; mc_wr_sel = DS; mc_wr_val = 16'h1234;
    cyc();
    mc_wr_en = 1'b0;
    rd_req = 3'b010; rd_sel[2*RD_LS +: 2] = DS;
    @(negedge clk);
    chk("single_ack", rd_ack, 3'b010);
    cyc();
    rd_req = '0;
    @(negedge clk);
    chk("single_valid", rd_valid, 3'b010);
    chk("single_data", rd_data, 16'h1234);
    cyc();

    // Fairness from reset.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    rd_req = 3'b111;
    rd_sel[2*RD_MC +: 2] = DS; rd_sel[2*RD_LS +: 2] = SS; rd_sel[2*RD_DBG +: 2] = CS;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      order[k] = rd_ack;
      cyc();
    end
    rd_req = '0;
    for (int k = 0; k < 6; k++) chk("fair_order", order[k], 3'b001 << (k % 3));
    cyc();

    // Write priority: debug waits until microcode goes quiet.
    dbg_wr_req = 1'b1; dbg_wr_sel = ES; dbg_wr_val = 16'hD0D0;
    rsel[0] = ES; rsel[1] = CS; rsel[2] = DS;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        mc_wr_en = 1'b1; mc_wr_sel = rsel[k]; mc_wr_val = 16'hA000 + 16'(k);
      end else begin
        mc_wr_en = 1'b0;
      end
      @(negedge clk);
      dack[k] = dbg_wr_ack;
      cyc();
    end
    dbg_wr_req = 1'b0;
    chk("dbg_ack_cycle", dack, 4'b1000);
    rexp[0] = 16'hD0D0; rexp[1] = 16'hA001; rexp[2] = 16'hA002;
    for (int k = 0; k < 3; k++) begin
      rd_req = 3'b001; rd_sel[2*RD_MC +: 2] = rsel[k];
      cyc();
      rd_req = '0;
      @(negedge clk);
      chk("wr_prio_data", rd_data, rexp[k]);
      cyc();
    end

    // Bypass: write SS and read SS in the same cycle.
    ssc = 0;
    mc_wr_en = 1'b1; mc_wr_sel = SS; mc_wr_val = 16'hBEEF;
    rd_req = 3'b001; rd_sel[2*RD_MC +: 2] = SS;
    @(negedge clk);
    ssc += int'(ss_loaded);
    cyc();
    mc_wr_en = 1'b0; rd_req = '0;
    @(negedge clk);
    chk("bypass_data", rd_data, 16'hBEEF);
    ssc += int'(ss_loaded);
    for (int k = 0; k < 3; k++) begin
      cyc();
      @(negedge clk);
      ssc += int'(ss_loaded);
    end
    chk("ss_pulses", ssc, 1);

    // Reset with a read in flight.
    cyc();
    rd_req = 3'b001;
    @(negedge clk);
    chk("midrst_ack", rd_ack, 3'b001);
    cyc();
    rd_req = '0; reset = 1'b1;
    @(negedge clk);
    chk("midrst_valid", rd_valid, 0);
    cyc();
    reset = 1'b0; rd_req = 3'b111;
    @(negedge clk);
    chk("post_rst_ptr", rd_ack, 3'b001);
    cyc();
    rd_req = '0;
    cyc();

    // Withdrawn request from debug while microcode is granted.
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    cnt2 = 0;
    rd_req = 3'b101;
    @(negedge clk);
    chk("withdraw_ack", rd_ack, 3'b001);
    cnt2 += int'(rd_ack[RD_DBG]) + int'(rd_valid[RD_DBG]);
    cyc();
    rd_req = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      cnt2 += int'(rd_ack[RD_DBG]) + int'(rd_valid[RD_DBG]);
      cyc();
    end
    chk("withdraw_none", cnt2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
